// File: rtl/mips_div_pkg.sv
// rtl/mips_div_pkg.sv - shared constants and state encodings for the MIPS divider
package mips_div_pkg;

  // Restoring steps for a full-width divide; also the default operand width.
  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/mips_div_step.sv
// rtl/mips_div_step.sv - one combinational restoring-division step
module mips_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  // One extra bit holds the bit shifted out of rem, so the trial compare is exact.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Shift {rem,quo} left, trial-subtract, keep on non-negative, otherwise restore.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, divisor_i};
    if (!diff[WIDTH]) begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mips_div.sv
// rtl/mips_div.sv - multi-cycle MIPS DIV/DIVU unit with flush and sign fix-up
module mips_div
  import mips_div_pkg::*;
#(
  parameter int WIDTH = DIV_ITERS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rmdr_q, rmdr_d;
  logic             dbz_out_q, dbz_out_d;

  logic             x_neg, y_neg;
  logic [WIDTH-1:0] x_mag, y_mag;
  logic [WIDTH-1:0] rem_nx, quo_nx;

  mips_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (rem_nx),
    .quo_o     (quo_nx)
  );

  // Operand magnitudes; negatives only exist for signed divides.
  always_comb begin
    x_neg = div_signed & dividend[WIDTH-1];
    y_neg = div_signed & divisor[WIDTH-1];
    x_mag = x_neg ? (~dividend + 1'b1) : dividend;
    y_mag = y_neg ? (~divisor + 1'b1) : divisor;
  end

  // Next-state logic: accept, iterate, apply signs, present results; flush aborts.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    dbz_d     = dbz_q;
    quot_d    = quot_q;
    rmdr_d    = rmdr_q;
    dbz_out_d = dbz_out_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          state_d = S_ITER;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = x_mag;
          dvs_d   = y_mag;
          r_neg_d = x_neg;
          dbz_d   = (divisor == '0);
          // A zero divisor leaves the all-ones quotient unsigned-looking.
          q_neg_d = (x_neg ^ y_neg) & (divisor != '0);
        end
      end
      S_ITER: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = S_FIX;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          state_d   = S_DONE;
          quot_d    = q_neg_q ? (~quo_q + 1'b1) : quo_q;
          rmdr_d    = r_neg_q ? (~rem_q + 1'b1) : rem_q;
          dbz_out_d = dbz_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      dbz_q     <= 1'b0;
      quot_q    <= '0;
      rmdr_q    <= '0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      dbz_q     <= dbz_d;
      quot_q    <= quot_d;
      rmdr_q    <= rmdr_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  // Status decoded straight from the state register.
  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    quotient    = quot_q;
    remainder   = rmdr_q;
    div_by_zero = dbz_out_q;
  end

endmodule

// File: tb/tb_mips_div.sv
// tb/tb_mips_div.sv - directed and reference-model checks for mips_div
module tb_mips_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        div_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;
  logic [31:0] prev_q;
  logic [31:0] prev_r;

  mips_div #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .div_signed  (div_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic model(input logic s, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] q, output logic [31:0] r);
    logic        xn, yn;
    logic [31:0] xm, ym, qm, rm;
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else begin
      xn = s & x[31];
      yn = s & y[31];
      xm = xn ? (32'd0 - x) : x;
      ym = yn ? (32'd0 - y) : y;
      qm = xm / ym;
      rm = xm % ym;
      q  = (xn ^ yn) ? (32'd0 - qm) : qm;
      r  = xn ? (32'd0 - rm) : rm;
    end
  endtask

  // Called at a negedge with the divider idle; returns at the negedge of the
  // first idle cycle after DONE so a following call issues back-to-back.
  task automatic do_div(input string tag, input logic s, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eq, input logic [31:0] er, input logic edbz);
    int busy_cnt;
    int done_cnt;
    int first_done;
    busy_cnt   = 0;
    done_cnt   = 0;
    first_done = 0;
    div_signed = s;
    dividend   = x;
    divisor    = y;
    start      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (first_done == 0) first_done = c;
      end
      if (c < 35) @(negedge clk);
    end
    check({tag, " done_cycle"}, 32'(first_done), 32'd34);
    check({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd34);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, edbz});
    prev_q = eq;
    prev_r = er;
  endtask

  initial begin
    logic [31:0] rq, rr, rx, ry;
    logic        rs;
    rst        = 1'b1;
    start      = 1'b0;
    flush      = 1'b0;
    div_signed = 1'b0;
    dividend   = '0;
    divisor    = '0;
    repeat (2) @(negedge clk);

    // Reset values, with start and flush asserted to show reset overrides them.
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset quotient", quotient, 32'd0);
    check("reset remainder", remainder, 32'd0);
    check("reset dbz", {31'd0, div_by_zero}, 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);

    // Hand-computed vectors, issued back-to-back.
    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    do_div("div_m7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0);
    do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    do_div("divu_ovf_ops", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    do_div("divu_by0", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    do_div("div_neg_by0", 1'b1, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1);
    do_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);

    // flush and start together in IDLE: nothing is accepted.
    div_signed = 1'b0;
    dividend   = 32'd50;
    divisor    = 32'd5;
    start      = 1'b1;
    flush      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("flush_wins busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("flush_wins busy2", {31'd0, busy}, 32'd0);

    // Re-start mid-divide is ignored, flush aborts, new divide follows.
    dividend = 32'd1000;
    divisor  = 32'd10;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    dividend = 32'd55;
    divisor  = 32'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", {31'd0, busy}, 32'd0);
    check("flush done", {31'd0, done}, 32'd0);
    check("flush keeps quotient", quotient, prev_q);
    check("flush keeps remainder", remainder, prev_r);
    do_div("after_flush_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    // Reset mid-divide clears outputs; start accepted on first edge with rst low.
    div_signed = 1'b1;
    dividend   = 32'hFFFF_FF00;
    divisor    = 32'd3;
    start      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    check("midrst quotient", quotient, 32'd0);
    check("midrst remainder", remainder, 32'd0);
    check("midrst dbz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;
    do_div("after_rst_m256_3", 1'b1, 32'hFFFF_FF00, 32'd3, 32'hFFFF_FFAB, 32'hFFFF_FFFF, 1'b0);

    // Randomised sweep against the reference model, mixing small and zero divisors.
    for (int i = 0; i < 12; i++) begin
      rs = i[0];
      rx = $urandom;
      case (i % 4)
        0: ry = $urandom;
        1: ry = $urandom_range(0, 5);
        2: ry = 32'd0 - $urandom_range(1, 9);
        default: ry = $urandom >> $urandom_range(0, 31);
      endcase
      if (i == 10) rx = 32'h8000_0000;
      if (i == 11) rx = 32'd0;
      model(rs, rx, ry, rq, rr);
      do_div($sformatf("rand%0d", i), rs, rx, ry, rq, rr, (ry == 32'd0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
